bus_grant_encoder: RTL and testbench

Parametrised, registered successor to the combinational 32-to-5 bus-select encoder. It arbitrates among N request lines and registers the winner as a binary index plus a one-hot vector. It holds the grant until the owner releases or drops its request, and supports fixed-priority or round-robin selection. It sits between the register-file/peripheral bus-drive requests and the bus multiplexer select, so bus ownership is stable across multi-cycle transfers.

---
 rtl/bus_grant_encoder.sv | 146 ++++++++++++++
 tb/tb_bus_grant_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_grant_encoder.sv
// ---------------------------------------------------------------------------
// bus_grant_encoder
//
// Registered N-way bus arbiter. It picks one requester out of req_i, registers
// it as a binary index and a one-hot vector, and holds that grant until the
// owner releases the bus or drops its request. The winner is chosen either by
// fixed priority (highest index wins) or by round-robin (search descending from
// the index just below the previous owner, wrapping modulo N).
//
// Parameters
//   N    number of request lines, 2..64, need not be a power of two
//   RR   0 = fixed priority, 1 = round-robin
//
// Ports
//   clk_i        system clock, rising edge
//   clr_i        synchronous active-high reset, overrides all other inputs
//   en_i         arbitration enable, looked at only while idle
//   req_i        request vector, bit i = requester i wants the bus
//   release_i    owner is done, looked at only while a grant is held
//   gnt_valid_o  a grant is currently held
//   gnt_idx_o    binary index of the owner, 0 when no grant
//   gnt_oh_o     one-hot of the owner, all zeros when no grant
// ---------------------------------------------------------------------------
module bus_grant_encoder #(
  parameter int N  = 32,
  parameter int RR = 0
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [N-1:0]          req_i,
  input  logic                  release_i,
  output logic                  gnt_valid_o,
  output logic [$clog2(N)-1:0]  gnt_idx_o,
  output logic [N-1:0]          gnt_oh_o
);

  localparam int IDXW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q,     state_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0]   gnt_idx_q,   gnt_idx_d;
  logic [N-1:0]      gnt_oh_q,    gnt_oh_d;
  logic [IDXW-1:0]   last_idx_q,  last_idx_d;

  // -------------------------------------------------------------------------
  // Winner search. Candidates are visited from lowest to highest precedence
  // so that the last hit written is the winner.
  // -------------------------------------------------------------------------
  logic              win_found;
  logic [IDXW-1:0]   win_idx;
  int                cand;
  logic [IDXW-1:0]   cand_idx;

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (RR == 0) begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i]) begin
          win_found = 1'b1;
          win_idx   = IDXW'(i);
        end
      end
    end else begin
      // Distance k from last_idx: k=1 is searched first, k=N (last_idx
      // itself) last. Wrap is done modulo N so no index >= N can appear.
      for (int k = N; k >= 1; k--) begin
        cand = int'(last_idx_q) + N - k;
        if (cand >= N) cand = cand - N;
        cand_idx = IDXW'(cand);
        if (req_i[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_oh_d    = gnt_oh_q;
    last_idx_d  = last_idx_q;

    unique case (state_q)
      IDLE: begin
        if (en_i && win_found) begin
          state_d            = HOLD;
          gnt_valid_d        = 1'b1;
          gnt_idx_d          = win_idx;
          gnt_oh_d           = '0;
          gnt_oh_d[win_idx]  = 1'b1;
        end
      end
      HOLD: begin
        // Explicit release or abandonment by the owner ends the grant; no new
        // arbitration in this cycle, the next grant comes one edge later.
        if (release_i || !req_i[gnt_idx_q]) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = '0;
          gnt_oh_d    = '0;
          last_idx_d  = gnt_idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      gnt_oh_q    <= '0;
      last_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_oh_q    <= gnt_oh_d;
      last_idx_q  <= last_idx_d;
    end
  end

  assign gnt_valid_o = gnt_valid_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_oh_o    = gnt_oh_q;

endmodule

// File: tb/tb_bus_grant_encoder.sv
// ---------------------------------------------------------------------------
// tb_bus_grant_encoder
//
// Three instances run side by side on one clock:
//   d0: N=32, fixed priority
//   d1: N=32, round-robin
//   d2: N=5,  round-robin (non-power-of-two wrap)
// A behavioural model (grant held / owner / previous owner, winner picked by a
// modulo-N search) predicts every output after every edge. Directed steps
// follow the intended scenarios, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_bus_grant_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // d0
  logic        clr0 = 1'b1, en0 = 1'b0, rel0 = 1'b0;
  logic [31:0] req0 = '0;
  logic        g0_valid;
  logic [4:0]  g0_idx;
  logic [31:0] g0_oh;
  // d1
  logic        clr1 = 1'b1, en1 = 1'b0, rel1 = 1'b0;
  logic [31:0] req1 = '0;
  logic        g1_valid;
  logic [4:0]  g1_idx;
  logic [31:0] g1_oh;
  // d2
  logic        clr2 = 1'b1, en2 = 1'b0, rel2 = 1'b0;
  logic [4:0]  req2 = '0;
  logic        g2_valid;
  logic [2:0]  g2_idx;
  logic [4:0]  g2_oh;

  bus_grant_encoder #(.N(32), .RR(0)) u_d0 (
    .clk_i(clk), .clr_i(clr0), .en_i(en0), .req_i(req0), .release_i(rel0),
    .gnt_valid_o(g0_valid), .gnt_idx_o(g0_idx), .gnt_oh_o(g0_oh)
  );
  bus_grant_encoder #(.N(32), .RR(1)) u_d1 (
    .clk_i(clk), .clr_i(clr1), .en_i(en1), .req_i(req1), .release_i(rel1),
    .gnt_valid_o(g1_valid), .gnt_idx_o(g1_idx), .gnt_oh_o(g1_oh)
  );
  bus_grant_encoder #(.N(5), .RR(1)) u_d2 (
    .clk_i(clk), .clr_i(clr2), .en_i(en2), .req_i(req2), .release_i(rel2),
    .gnt_valid_o(g2_valid), .gnt_idx_o(g2_idx), .gnt_oh_o(g2_oh)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model state per instance
  const int n_of [3] = '{32, 32, 5};
  const bit rr_of[3] = '{1'b0, 1'b1, 1'b1};
  bit m_held[3];
  int m_idx [3];
  int m_last[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Winner per the selection rules: fixed = highest set bit; round-robin =
  // first set bit at distance 1, 2, ..., n below the previous owner (mod n).
  function automatic int pick(input int n, input bit rr, input logic [63:0] r, input int last);
    if (rr) begin
      for (int k = 1; k <= n; k++) begin
        int c;
        c = (last - k + n) % n;
        if (r[c]) return c;
      end
    end else begin
      for (int i = n - 1; i >= 0; i--)
        if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [63:0] mask_n(input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_step(input int d, input bit c, input bit e, input logic [63:0] r, input bit rl);
    logic [63:0] rm;
    rm = r & mask_n(n_of[d]);
    if (c) begin
      m_held[d] = 1'b0; m_idx[d] = 0; m_last[d] = 0;
    end else if (!m_held[d]) begin
      if (e && rm != 0) begin
        m_held[d] = 1'b1;
        m_idx[d]  = pick(n_of[d], rr_of[d], rm, m_last[d]);
      end
    end else if (rl || !rm[m_idx[d]]) begin
      m_held[d] = 1'b0;
      m_last[d] = m_idx[d];
      m_idx[d]  = 0;
    end
  endtask

  task automatic check_dut(input int d, input logic v, input logic [63:0] idx, input logic [63:0] oh);
    logic [63:0] exp_oh;
    exp_oh = m_held[d] ? (64'd1 << m_idx[d]) : 64'd0;
    check($sformatf("d%0d_valid", d), 64'(v), 64'(m_held[d]));
    check($sformatf("d%0d_idx", d), idx, 64'(m_idx[d]));
    check($sformatf("d%0d_oh", d), oh, exp_oh);
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic tick();
    model_step(0, clr0, en0, 64'(req0), rel0);
    model_step(1, clr1, en1, 64'(req1), rel1);
    model_step(2, clr2, en2, 64'(req2), rel2);
    @(posedge clk);
    #1;
    check_dut(0, g0_valid, 64'(g0_idx), 64'(g0_oh));
    check_dut(1, g1_valid, 64'(g1_idx), 64'(g1_oh));
    check_dut(2, g2_valid, 64'(g2_idx), 64'(g2_oh));
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_held[d] = 1'b0; m_idx[d] = 0; m_last[d] = 0;
    end

    // Reset state
    tick();
    tick();
    check("reset_valid", 64'(g0_valid), 64'd0);
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;

    // Fixed priority: highest bit wins, then release, then next grant
    req0 = 32'h8000_0012; en0 = 1'b1;
    tick();
    check("fp_idx31", 64'(g0_idx), 64'd31);
    check("fp_oh31", 64'(g0_oh), 64'h8000_0000);
    tick();                                   // held, no release
    rel0 = 1'b1;
    tick();
    check("fp_release", 64'(g0_valid), 64'd0);
    rel0 = 1'b0; req0 = 32'h0000_0012;
    tick();
    check("fp_idx4", 64'(g0_idx), 64'd4);

    // Abandon: owner 4 drops its request
    req0 = 32'h8000_0000;
    tick();
    check("abandon_drop", 64'(g0_valid), 64'd0);
    tick();
    check("abandon_regrant31", 64'(g0_idx), 64'd31);
    // While held, en and other req bits do nothing
    en0 = 1'b0; req0 = 32'h8000_FFFF;
    tick();
    req0 = 32'hC000_0001;
    tick();
    check("hold_ignore", 64'(g0_idx), 64'd31);
    rel0 = 1'b1;
    tick();
    rel0 = 1'b0; en0 = 1'b1;

    // Reset mid-grant
    req0 = 32'h0000_0080;
    tick();
    check("mid_grant7", 64'(g0_idx), 64'd7);
    clr0 = 1'b1;
    tick();
    check("mid_clr_valid", 64'(g0_valid), 64'd0);
    check("mid_clr_oh", 64'(g0_oh), 64'd0);
    clr0 = 1'b0;
    tick();
    check("mid_regrant7", 64'(g0_idx), 64'd7);
    rel0 = 1'b1;
    tick();
    rel0 = 1'b0; req0 = '0;

    // Round-robin N=32: 31, 4, 1, 31 with one idle cycle between
    req1 = 32'h8000_0012; en1 = 1'b1; rel1 = 1'b1;
    tick(); check("rr_g31a", 64'(g1_idx), 64'd31);
    tick(); check("rr_gap1", 64'(g1_valid), 64'd0);
    tick(); check("rr_g4",   64'(g1_idx), 64'd4);
    tick();
    tick(); check("rr_g1",   64'(g1_idx), 64'd1);
    tick();
    tick(); check("rr_g31b", 64'(g1_idx), 64'd31);
    tick();
    req1 = '0; rel1 = 1'b0;

    // Non-power-of-two wrap N=5: 4, 0, 4
    req2 = 5'b10001; en2 = 1'b1; rel2 = 1'b1;
    tick(); check("np_g4a", 64'(g2_idx), 64'd4);
    tick();
    tick(); check("np_g0",  64'(g2_idx), 64'd0);
    tick();
    tick(); check("np_g4b", 64'(g2_idx), 64'd4);
    tick();
    // last_idx searched last: after reset last_idx=0, only req 0
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0; req2 = 5'b00001;
    tick(); check("np_last_self", 64'(g2_idx), 64'd0);
    tick();
    rel2 = 1'b0; req2 = '0;
    tick();

    // Randomized phase, all three instances
    for (int t = 0; t < 600; t++) begin
      clr0 = ($urandom_range(0, 40) == 0);
      clr1 = ($urandom_range(0, 40) == 0);
      clr2 = ($urandom_range(0, 40) == 0);
      en0  = ($urandom_range(0, 3) != 0);
      en1  = ($urandom_range(0, 3) != 0);
      en2  = ($urandom_range(0, 3) != 0);
      rel0 = ($urandom_range(0, 3) == 0);
      rel1 = ($urandom_range(0, 3) == 0);
      rel2 = ($urandom_range(0, 3) == 0);
      req0 = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom & $urandom & $urandom);
      req1 = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom & $urandom);
      req2 = 5'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
